// File: rtl/memory_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM encodings and
// requester identifiers used by the top level and the round-robin picker.
package memory_arbiter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ISSUE = ST_ISSUE,
    RESP  = ST_RESP
  } state_t;

  localparam logic REQ_INST = 1'b0;
  localparam logic REQ_DATA = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Two-input round-robin grant. A lone requester always wins; on contention
// the requester named by ptr wins.
module rr_pick2
  import memory_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       grant_valid,
  output logic       grant_id
);

  always_comb begin
    grant_valid = |req;
    grant_id    = ptr;
    if (req[REQ_INST] && !req[REQ_DATA]) begin
      grant_id = REQ_INST;
    end else if (req[REQ_DATA] && !req[REQ_INST]) begin
      grant_id = REQ_DATA;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one synchronous
// single-port memory; each access takes IDLE -> ISSUE -> RESP (3 cycles).
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int  MEMORY_DEPTH = 1024,
  parameter bit  DATA_FIRST   = 1'b0,
  localparam int AW           = $clog2(MEMORY_DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_inst_stb,
  input  logic [31:0]   i_inst_addr,
  output logic          o_inst_ack,
  input  logic          i_data_stb,
  input  logic [31:0]   i_data_addr,
  input  logic          i_data_wr_en,
  input  logic [3:0]    i_data_wr_mask,
  input  logic [31:0]   i_data_wdata,
  output logic          o_data_ack,
  output logic [31:0]   o_rdata,
  output logic          o_mem_en,
  output logic [AW-3:0] o_mem_addr,
  output logic          o_mem_wr_en,
  output logic [3:0]    o_mem_wr_mask,
  output logic [31:0]   o_mem_wdata,
  input  logic [31:0]   i_mem_rdata
);

  state_t        state_reg, state_next;
  logic          ptr_reg;
  logic          owner_reg;
  logic          wr_en_reg;
  logic [AW-3:0] addr_reg;
  logic [3:0]    mask_reg;
  logic [31:0]   wdata_reg;
  logic          grant_valid;
  logic          grant_id;
  logic          grant;

  // Address bits outside the memory window and the byte offset are ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_inst_addr[31:AW], i_inst_addr[1:0],
                              i_data_addr[31:AW], i_data_addr[1:0]};

  rr_pick2 u_pick (
    .req         ({i_data_stb, i_inst_stb}),
    .ptr         (ptr_reg),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign grant = (state_reg == IDLE) && grant_valid;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant_valid) state_next = ISSUE;
      ISSUE:   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg <= IDLE;
      ptr_reg   <= DATA_FIRST;
      owner_reg <= REQ_INST;
      wr_en_reg <= 1'b0;
      addr_reg  <= '0;
      mask_reg  <= 4'b0000;
      wdata_reg <= 32'd0;
    end else begin
      state_reg <= state_next;
      if (grant) begin
        owner_reg <= grant_id;
        ptr_reg   <= ~grant_id;
        if (grant_id == REQ_DATA) begin
          addr_reg  <= i_data_addr[AW-1:2];
          wr_en_reg <= i_data_wr_en;
          mask_reg  <= i_data_wr_mask;
          wdata_reg <= i_data_wdata;
        end else begin
          // Instruction fetches are read-only, so lane enables stay clear.
          addr_reg  <= i_inst_addr[AW-1:2];
          wr_en_reg <= 1'b0;
          mask_reg  <= 4'b0000;
          wdata_reg <= 32'd0;
        end
      end
    end
  end

  always_comb begin
    o_mem_en      = (state_reg == ISSUE);
    o_mem_wr_en   = (state_reg == ISSUE) && wr_en_reg;
    o_mem_addr    = addr_reg;
    o_mem_wr_mask = mask_reg;
    o_mem_wdata   = wdata_reg;
    o_inst_ack    = (state_reg == RESP) && (owner_reg == REQ_INST);
    o_data_ack    = (state_reg == RESP) && (owner_reg == REQ_DATA);
    o_rdata       = (state_reg == RESP) ? i_mem_rdata : 32'd0;
  end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 SHALL have parameter MEMORY_DEPTH, default 1024, meaning memory size in bytes; AW = clog2(MEMORY_DEPTH).
REQ-002 SHALL have parameter DATA_FIRST, default 0, meaning the requester favoured by the round-robin pointer after reset (0 = inst, 1 = data).
REQ-003 SHALL have one clock, i_clk; all state is updated on its rising edge.
REQ-004 SHALL have reset i_rst_n, which is synchronous and active-low.
REQ-005 i_inst_stb  in  1  instruction-fetch request, held until ack.
REQ-006 i_inst_addr  in  32  instruction byte address.
REQ-007 o_inst_ack  out  1  one-cycle completion pulse for inst.
REQ-008 i_data_stb  in  1  data request, held until ack.
REQ-009 i_data_addr  in  32  data byte address.
REQ-010 i_data_wr_en  in  1  1 = write, 0 = read.
REQ-011 i_data_wr_mask  in  4  byte-lane write enables.
REQ-012 i_data_wdata  in  32  store data.
REQ-013 o_data_ack  out  1  one-cycle completion pulse for data.
REQ-014 o_rdata  out  32  read data, shared; valid only while an ack is high.
REQ-015 o_mem_en  out  1  memory access strobe.
REQ-016 o_mem_addr  out  AW-2  memory word address.
REQ-017 o_mem_wr_en  out  1  memory write enable.
REQ-018 o_mem_wr_mask  out  4  memory byte-lane enables.
REQ-019 o_mem_wdata  out  32  memory write data.
REQ-020 i_mem_rdata  in  32  synchronous memory read data, valid one cycle after o_mem_en.

Function
REQ-021 SHALL implement an FSM with states IDLE, ISSUE and RESP, using transitions IDLE->ISSUE on a granted request, ISSUE->RESP and RESP->IDLE unconditionally.
REQ-022 In IDLE with any stb high, the block SHALL select a winner, register its addr/wr_en/wr_mask/wdata onto the o_mem_* outputs and enter ISSUE.
REQ-023 Arbitration: a single requester SHALL win; when both request, the requester not granted last SHALL win, and the pointer SHALL update on every grant.
REQ-024 In ISSUE, o_mem_en SHALL be 1 for exactly one cycle, with o_mem_wr_en = wr_en of the winner.
REQ-025 Inst requests SHALL never write: o_mem_wr_en = 0 and o_mem_wr_mask = 0.
REQ-026 In RESP, exactly the winner's ack SHALL be 1, and o_rdata SHALL equal i_mem_rdata; o_rdata is don't-care for writes.
REQ-027 Latency: ack SHALL occur two cycles after the grant edge; throughput is one access per 3 cycles.
REQ-028 o_mem_addr SHALL be addr[AW-1:2]; higher address bits are ignored, so addresses wrap modulo MEMORY_DEPTH, and bits [1:0] are ignored.
REQ-029 A stb dropped after grant SHALL NOT abort the access; it completes and still acks.
REQ-030 Stb high in the IDLE cycle after an ack SHALL be treated as a new request.
REQ-031 Requests arriving during ISSUE/RESP SHALL wait; the losing requester's stb is held and served no later than the next IDLE grant (no starvation).
REQ-032 A write with wr_mask = 0 SHALL still take 3 cycles and ack, with no byte modified.
REQ-033 o_mem_en, o_mem_wr_en, o_inst_ack and o_data_ack SHALL be 0 in all other states.

Reset
REQ-034 When i_rst_n = 0 at a clock edge, in any state, the block SHALL set FSM = IDLE, all outputs = 0 and pointer = DATA_FIRST.
REQ-035 Reset during ISSUE/RESP SHALL abort the access with no ack and no further mem strobe, and a write already strobed stands.

Structure
REQ-036 FSM state encodings and requester IDs (INST=0, DATA=1) SHALL be localparams in the shared core header.
REQ-037 Sub-module rr_pick2 (two-input round-robin grant, combinational, pointer input) SHALL be used; everything else is inline.

Verification
REQ-038 Inst-only read addr 0x10, mem word 4 = 0x00000013: o_mem_en at cycle+1 with o_mem_addr = 4, then o_inst_ack with o_rdata = 0x00000013 at cycle+2.
REQ-039 Data write addr 0x22, mask 0b0100, wdata 0x00AB0000, then read back: the byte lands in word 8 lane 2 only.
REQ-040 Both stb held continuously from reset: grants alternate inst, data, inst, data, with acks every 3 cycles and no ack overlap.
REQ-041 Addr 0x400 with MEMORY_DEPTH = 1024: o_mem_addr = 0, confirming wrap.
REQ-042 Reset asserted in ISSUE: no ack, outputs 0 next cycle, and the next request is served normally from IDLE.
REQ-043 Inst stb dropped during ISSUE: o_inst_ack still pulses once, and no second access follows.
